// File: rtl/uart_rx_fifo_if.sv
// Read/write handshake bundle between the UART receiver, the receive FIFO and
// the consumer.
interface uart_rx_fifo_if #(
  parameter int DBIT_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  rx_done_tick;
  logic [DBIT_WIDTH-1:0] rx_data;
  logic                  rd_ready;
  logic                  ovf_clr;
  logic                  rd_valid;
  logic [DBIT_WIDTH-1:0] rd_data;
  logic                  full;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;

  // The environment drives the strobes; the FIFO answers with its status.
  modport master (
    output rx_done_tick, rx_data, rd_ready, ovf_clr,
    input  rd_valid, rd_data, full, level, overflow
  );

  modport slave (
    input  rx_done_tick, rx_data, rd_ready, ovf_clr,
    output rd_valid, rd_data, full, level, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind a UART receiver. Bytes that arrive
// while full are dropped and flagged through a sticky overflow bit.
module uart_rx_fifo #(
  parameter int DBIT_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  uart_rx_fifo_if.slave bus
);
  localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = DEPTH[ADDR_WIDTH:0];

  logic [DBIT_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic                  overflow_q;

  logic rd_valid;
  logic full;
  logic push;
  logic pop;
  logic drop;

  assign rd_valid = (level_q != '0);
  assign full     = (level_q == FULL_LEVEL);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte.
  assign pop  = bus.rd_ready & rd_valid;
  assign push = bus.rx_done_tick & (~full | pop);
  assign drop = bus.rx_done_tick & full & ~pop;

  // NOTE: the storage array has no reset; the pointers and level alone decide
  // which entries hold live data, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  // NOTE: non-blocking assignments so every register here samples the
  // pre-edge values of push/pop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (ADDR_WIDTH + 1)'(1);
        2'b01:   level_q <= level_q - (ADDR_WIDTH + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign bus.full     = full;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill/overrun, wrap and reset corners.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_fifo_if #(.DBIT_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_rx_fifo #(.DBIT_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_level;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] model[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, return at the next falling edge.
  task automatic step(input logic tick, input logic [7:0] data, input logic rdy, input logic clr);
    bus.rx_done_tick = tick;
    bus.rx_data      = data;
    bus.rd_ready     = rdy;
    bus.ovf_clr      = clr;
    @(posedge clk);
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rd_ready     = 1'b0;
    bus.ovf_clr      = 1'b0;
  endtask

  // Check the head byte before the popping edge, then pop it.
  task automatic pop_expect(input string name, input logic [7:0] exp);
    check(name, {31'd0, bus.rd_valid}, 32'd1);
    check(name, {24'd0, bus.rd_data}, {24'd0, exp});
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic fill_0_to_15();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
    end
    check("fill.level", {27'd0, bus.level}, 32'd16);
    check("fill.full", {31'd0, bus.full}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rd_ready     = 1'b0;
    bus.ovf_clr      = 1'b0;

    // tick data rdy clr | valid data level full ovf (after the edge)
    vecs[0] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'h55, 5'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h55, 5'd3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA3, 5'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h0F, 5'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.valid", {31'd0, bus.rd_valid}, 32'd0);
    check("reset.data", {24'd0, bus.rd_data}, 32'd0);
    check("reset.level", {27'd0, bus.level}, 32'd0);
    check("reset.full", {31'd0, bus.full}, 32'd0);
    check("reset.ovf", {31'd0, bus.overflow}, 32'd0);

    // In-order transfer, empty-read ignore and empty write+ready corner.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].tick, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d.valid", i), {31'd0, bus.rd_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d.data", i), {24'd0, bus.rd_data}, {24'd0, vecs[i].e_data});
      check($sformatf("vec%0d.level", i), {27'd0, bus.level}, {27'd0, vecs[i].e_level});
      check($sformatf("vec%0d.full", i), {31'd0, bus.full}, {31'd0, vecs[i].e_full});
      check($sformatf("vec%0d.ovf", i), {31'd0, bus.overflow}, {31'd0, vecs[i].e_ovf});
    end

    // Fill, overrun, clear-vs-drop priority, then drain without the dropped bytes.
    fill_0_to_15();
    check("fill.ovf", {31'd0, bus.overflow}, 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check("drop.ovf", {31'd0, bus.overflow}, 32'd1);
    check("drop.level", {27'd0, bus.level}, 32'd16);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    check("clr_drop.ovf", {31'd0, bus.overflow}, 32'd1);
    check("clr_drop.level", {27'd0, bus.level}, 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr.ovf", {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      pop_expect($sformatf("drain%0d", i), 8'(i));
    end
    check("drained.valid", {31'd0, bus.rd_valid}, 32'd0);
    check("drained.level", {27'd0, bus.level}, 32'd0);

    // Simultaneous write and pop while full.
    fill_0_to_15();
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("simul.level", {27'd0, bus.level}, 32'd16);
    check("simul.ovf", {31'd0, bus.overflow}, 32'd0);
    check("simul.full", {31'd0, bus.full}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      pop_expect($sformatf("simul_drain%0d", i), 8'(i));
    end
    pop_expect("simul_last", 8'h77);
    check("simul_end.valid", {31'd0, bus.rd_valid}, 32'd0);

    // Interleaved push/pop across pointer wraps, level held in 1..3.
    model.delete();
    begin
      logic [7:0] pat;
      pat = 8'h80;
      for (int c = 0; c < 40; c++) begin
        logic do_push;
        logic do_pop;
        do_push = (c % 4 != 3);
        do_pop  = (model.size() >= 2);
        if (do_pop) begin
          check($sformatf("wrap%0d.head", c), {24'd0, bus.rd_data}, {24'd0, model[0]});
          void'(model.pop_front());
        end
        if (do_push) model.push_back(pat);
        step(do_push, pat, do_pop, 1'b0);
        if (do_push) pat = pat + 8'd1;
        check($sformatf("wrap%0d.level", c), {27'd0, bus.level}, model.size());
      end
      while (model.size() > 0) begin
        pop_expect("wrap_tail", model.pop_front());
      end
      check("wrap_end.valid", {31'd0, bus.rd_valid}, 32'd0);
    end

    // Asynchronous reset with data in flight.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    end
    check("prerst.level", {27'd0, bus.level}, 32'd5);
    #2 rst = 1'b1;
    #1;
    check("rst.valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst.level", {27'd0, bus.level}, 32'd0);
    check("rst.data", {24'd0, bus.rd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("postrst.level", {27'd0, bus.level}, 32'd1);
    pop_expect("postrst.head", 8'h5A);
    check("postrst.valid", {31'd0, bus.rd_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the host/consumer logic. Captures each byte on the receiver's one-cycle `rx_done_tick` pulse and queues it in a first-word-fall-through FIFO. Presents the oldest byte through a valid/ready read port and reports occupancy. Flags overrun with a sticky error bit when a byte arrives while the FIFO is full.

## Interface
- `DBIT_WIDTH`, 8: byte width; must match the receiver's data width.
- `ADDR_WIDTH`, 4: pointer width; depth is `DEPTH = 2**ADDR_WIDTH` (16). Legal values are ≥1.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_done_tick`  in  1  write strobe. One-cycle pulse from the receiver.
- `rx_data`  in  DBIT_WIDTH  byte to store; sampled only in cycles where `rx_done_tick`=1.
- `rd_ready`  in  1  consumer accepts the head byte this cycle.
- `ovf_clr`  in  1  clears `overflow`.
- `rd_valid`  out  1  FIFO not empty; `rd_data` holds the head byte.
- `rd_data`  out  DBIT_WIDTH  head byte; all zeros when `rd_valid`=0.
- `full`  out  1  level == DEPTH.
- `level`  out  ADDR_WIDTH+1  number of stored bytes, 0..DEPTH.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- Storage is a `DEPTH`×`DBIT_WIDTH` array, which is not reset.
- `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits wide and wrap naturally modulo DEPTH.
- `level` is a registered counter. `rd_valid`, `full` and `rd_data` are derived combinationally from registered state.
- Push: `push = rx_done_tick & (~full | pop)`.
  - On push: mem[wr_ptr] ← rx_data, and wr_ptr increments.
- Pop: `pop = rd_ready & rd_valid`.
  - On pop: rd_ptr increments.
  - `rd_ready` while empty is ignored; no pointer or level change.
- Level update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Full with simultaneous write and pop: both take effect. Level stays DEPTH. No overflow.
- Drop: `rx_done_tick` while full and no pop → byte discarded; pointers and level unchanged; `overflow` ← 1.
- `overflow` clear: `ovf_clr`=1 clears it, but a drop in the same cycle wins and `overflow` stays 1.
- Empty with simultaneous write and `rd_ready`: no pop. The byte is stored and level becomes 1.
- `rd_data` = mem[rd_ptr] when `rd_valid`, else 0.
- Byte order is strictly arrival order.
- No state machine beyond pointer/level bookkeeping. The block is a pure buffer and never back-pressures the receiver.

## Timing
- Reset (async assert, released synchronously with `clk`): wr_ptr=0, rd_ptr=0, level=0, overflow=0. As a result rd_valid=0, rd_data=0, full=0.
- Reset mid-operation discards all stored bytes immediately. `rd_valid` falls asynchronously with `rst`.
- Write latency: byte on `rx_done_tick` at edge N:
  - appears on `rd_data` with `rd_valid`=1 after edge N (first-word fall-through),
  - and `level` reflects it after edge N.
- Pop: head advances at the edge where `rd_valid & rd_ready`=1. The next byte, or zero/`rd_valid`=0, is visible right after that edge.
- Back-to-back `rx_done_tick` on consecutive cycles must be accepted, one byte per cycle.
- `overflow` sets at the edge of the dropping cycle and is visible the following cycle.

## Test plan
- **In-order transfer:** reset, then push 0x55, 0xA3, 0x0F with `rd_ready`=0 → level=3, rd_data=0x55. Then hold `rd_ready`=1 → reads 0x55, 0xA3, 0x0F on consecutive cycles. Then rd_valid=0, rd_data=0x00, level=0.
- **Fill and overrun:** push 16 bytes 0x00..0x0F → full=1, level=16, overflow=0. Push 0xEE → overflow=1, level=16. Drain → 0x00..0x0F in order with 0xEE absent.
- **Simultaneous at full:** with FIFO full (0x00..0x0F), push 0x77 with `rd_ready`=1 in the same cycle → 0x00 popped, level=16, overflow=0. The last byte drained is 0x77.
- **Empty corner:** with FIFO empty, `rx_done_tick`=1 with rx_data=0x3C and `rd_ready`=1 → next cycle level=1, rd_valid=1, rd_data=0x3C.
- **Pointer wrap:** 40 interleaved push/pop cycles of an incrementing pattern with level kept between 1 and 3 → every byte is read in order across multiple pointer wraps.
- **Overflow clear and reset:**
  - With overflow=1, assert `ovf_clr` together with a drop → overflow stays 1.
  - `ovf_clr` alone → overflow=0.
  - Assert `rst` mid-stream with level=5 → rd_valid=0 and level=0 immediately. After release, the first new push is read back correctly.
